// File: rtl/dm_cache_pkg.sv
// Shared types and geometry for the direct-mapped cache: set/line sizing,
// controller state encoding and the byte-lane write merge.
package cache_types;

    localparam int S_OFFSET = 5;
    localparam int S_INDEX  = 3;
    localparam int S_TAG    = 32 - S_OFFSET - S_INDEX;
    localparam int LINE_W   = 8 << S_OFFSET;

    typedef enum logic [1:0] {IDLE, COMPARE, WRITEBACK, ALLOCATE} cache_state_t;

    typedef logic [LINE_W-1:0] line_t;
    typedef logic [S_TAG-1:0]  tag_t;

    // Overlay the enabled byte lanes of one 32-bit word onto a line.
    function automatic line_t merge_word(input line_t line, input int unsigned word,
                                         input logic [31:0] wdata, input logic [3:0] be);
        line_t m;
        m = line;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) m[32*word + 8*b +: 8] = wdata[8*b +: 8];
        end
        return m;
    endfunction

endpackage

// File: rtl/dm_cache_control.sv
// Cache controller FSM: sequences tag compare, dirty-line writeback and line
// fill, and emits the strobes that update the arrays held in dm_cache.
module cache_control
    import cache_types::*;
(
    input  logic clk,
    input  logic rst,
    input  logic mem_read,
    input  logic mem_write,
    input  logic hit,
    input  logic dirty,
    input  logic req_write,
    input  logic pmem_resp,
    output logic load_req,
    output logic load_line,
    output logic set_dirty,
    output logic clr_dirty,
    output logic set_valid,
    output logic addr_sel,
    output logic pmem_read,
    output logic pmem_write,
    output logic mem_resp
);

    cache_state_t state, state_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        load_req   = 1'b0;
        load_line  = 1'b0;
        set_dirty  = 1'b0;
        clr_dirty  = 1'b0;
        set_valid  = 1'b0;
        addr_sel   = 1'b0;
        pmem_read  = 1'b0;
        pmem_write = 1'b0;
        mem_resp   = 1'b0;
        unique case (state)
            IDLE: begin
                if (mem_read || mem_write) begin
                    load_req   = 1'b1;
                    state_next = COMPARE;
                end
            end
            COMPARE: begin
                if (hit) begin
                    mem_resp   = 1'b1;
                    set_dirty  = req_write;
                    state_next = IDLE;
                end else begin
                    state_next = dirty ? WRITEBACK : ALLOCATE;
                end
            end
            // addr_sel points pmem_address at the victim's tag, not the request's
            WRITEBACK: begin
                pmem_write = 1'b1;
                addr_sel   = 1'b1;
                if (pmem_resp) begin
                    clr_dirty  = 1'b1;
                    state_next = ALLOCATE;
                end
            end
            ALLOCATE: begin
                pmem_read = 1'b1;
                if (pmem_resp) begin
                    load_line  = 1'b1;
                    set_valid  = 1'b1;
                    state_next = COMPARE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: rtl/dm_cache.sv
// Direct-mapped write-back, write-allocate cache between the core's word port
// and 256-bit line memory. Holds the arrays, request latch, hit compare and merge.
module dm_cache #(
    parameter int S_OFFSET = cache_types::S_OFFSET,
    parameter int S_INDEX  = cache_types::S_INDEX,
    parameter int S_TAG    = cache_types::S_TAG
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         mem_read,
    input  logic         mem_write,
    input  logic [31:0]  mem_address,
    input  logic [31:0]  mem_wdata,
    input  logic [3:0]   mem_byte_enable,
    output logic [31:0]  mem_rdata,
    output logic         mem_resp,
    output logic         pmem_read,
    output logic         pmem_write,
    output logic [31:0]  pmem_address,
    output logic [255:0] pmem_wdata,
    input  logic [255:0] pmem_rdata,
    input  logic         pmem_resp
);
    import cache_types::line_t;
    import cache_types::merge_word;

    localparam int SETS   = 1 << S_INDEX;
    localparam int WORD_W = S_OFFSET - 2;

    logic [S_TAG-1:0]   req_tag;
    logic [S_INDEX-1:0] req_idx;
    logic [WORD_W-1:0]  req_word;
    logic [31:0]        req_wdata;
    logic [3:0]         req_be;
    logic               req_write;

    logic [SETS-1:0]    valid;
    logic [SETS-1:0]    dirty;
    logic [S_TAG-1:0]   tags [SETS];
    line_t              data [SETS];

    logic load_req, load_line, set_dirty, clr_dirty, set_valid, addr_sel, hit;
    line_t              cur_line;
    logic [S_TAG-1:0]   cur_tag;
    logic               unused_addr_bits;

    assign unused_addr_bits = ^mem_address[1:0];
    assign cur_line = data[req_idx];
    assign cur_tag  = tags[req_idx];
    assign hit      = valid[req_idx] && (cur_tag == req_tag);

    cache_control u_ctrl (
        .clk        (clk),
        .rst        (rst),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .hit        (hit),
        .dirty      (dirty[req_idx]),
        .req_write  (req_write),
        .pmem_resp  (pmem_resp),
        .load_req   (load_req),
        .load_line  (load_line),
        .set_dirty  (set_dirty),
        .clr_dirty  (clr_dirty),
        .set_valid  (set_valid),
        .addr_sel   (addr_sel),
        .pmem_read  (pmem_read),
        .pmem_write (pmem_write),
        .mem_resp   (mem_resp)
    );

    // Core inputs are captured once; the transaction runs on these copies.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_tag   <= '0;
            req_idx   <= '0;
            req_word  <= '0;
            req_wdata <= '0;
            req_be    <= '0;
            req_write <= 1'b0;
        end else if (load_req) begin
            req_tag   <= mem_address[31 -: S_TAG];
            req_idx   <= mem_address[S_OFFSET +: S_INDEX];
            req_word  <= mem_address[2 +: WORD_W];
            req_wdata <= mem_wdata;
            req_be    <= mem_byte_enable;
            req_write <= mem_write;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= '0;
            dirty <= '0;
        end else begin
            if (set_valid)              valid[req_idx] <= 1'b1;
            if (load_line || clr_dirty) dirty[req_idx] <= 1'b0;
            if (set_dirty)              dirty[req_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (load_line) begin
            data[req_idx] <= pmem_rdata;
            tags[req_idx] <= req_tag;
        end else if (set_dirty) begin
            data[req_idx] <= merge_word(cur_line, 32'(req_word), req_wdata, req_be);
        end
    end

    assign mem_rdata    = (mem_resp && !req_write) ? cur_line[{req_word, 5'b0} +: 32] : '0;
    assign pmem_address = (pmem_read || pmem_write)
                        ? {(addr_sel ? cur_tag : req_tag), req_idx, {S_OFFSET{1'b0}}} : '0;
    assign pmem_wdata   = pmem_write ? cur_line : '0;

endmodule

// File: tb/tb_dm_cache.sv
// Randomized bench for dm_cache: a word-level memory model plus set-occupancy
// model predict read data, hit latency and the exact pmem traffic per access.
module tb_dm_cache;

    logic         clk = 1'b0;
    logic         rst;
    logic         mem_read, mem_write;
    logic [31:0]  mem_address, mem_wdata;
    logic [3:0]   mem_byte_enable;
    logic [31:0]  mem_rdata;
    logic         mem_resp;
    logic         pmem_read, pmem_write;
    logic [31:0]  pmem_address;
    logic [255:0] pmem_wdata;
    logic [255:0] pmem_rdata;
    logic         pmem_resp;

    dm_cache dut (
        .clk             (clk),
        .rst             (rst),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .mem_address     (mem_address),
        .mem_wdata       (mem_wdata),
        .mem_byte_enable (mem_byte_enable),
        .mem_rdata       (mem_rdata),
        .mem_resp        (mem_resp),
        .pmem_read       (pmem_read),
        .pmem_write      (pmem_write),
        .pmem_address    (pmem_address),
        .pmem_wdata      (pmem_wdata),
        .pmem_rdata      (pmem_rdata),
        .pmem_resp       (pmem_resp)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    typedef struct {
        bit           wr;
        logic [31:0]  addr;
        logic [255:0] data;
    } tx_t;

    logic [255:0] pmem_store [logic [26:0]];
    logic [31:0]  ref_mem    [logic [29:0]];
    logic [23:0]  ctag   [8];
    bit           cval   [8];
    bit           cdirty [8];
    tx_t          txq [$];
    int           fixed_delay = -1;

    function automatic logic [255:0] init_line(input logic [26:0] la);
        logic [255:0] l;
        logic [31:0]  a;
        for (int w = 0; w < 8; w++) begin
            a = {la, 5'b0} + 32'(4 * w);
            l[32*w +: 32] = a * 32'h9E37_79B1 + 32'h0123_4567;
        end
        return l;
    endfunction

    function automatic logic [255:0] pmem_line(input logic [26:0] la);
        if (pmem_store.exists(la)) return pmem_store[la];
        return init_line(la);
    endfunction

    function automatic logic [31:0] ref_word(input logic [31:0] a);
        logic [255:0] l;
        if (ref_mem.exists(a[31:2])) return ref_mem[a[31:2]];
        l = pmem_line(a[31:5]);
        return l[32*a[4:2] +: 32];
    endfunction

    function automatic logic [255:0] ref_line(input logic [26:0] la);
        logic [255:0] l;
        for (int w = 0; w < 8; w++) l[32*w +: 32] = ref_word({la, 5'b0} + 32'(4 * w));
        return l;
    endfunction

    // Physical memory: random or fixed latency, one response per request.
    bit          pm_busy = 1'b0;
    int          pm_cnt  = 0;
    logic [31:0] pm_start;
    tx_t         pm_tx;

    initial begin
        pmem_resp  = 1'b0;
        pmem_rdata = '0;
        forever begin
            @(negedge clk);
            pmem_resp = 1'b0;
            if (rst) begin
                pm_busy = 1'b0;
            end else if (pmem_read || pmem_write) begin
                if (!pm_busy) begin
                    pm_busy  = 1'b1;
                    pm_cnt   = (fixed_delay >= 0) ? fixed_delay : int'($urandom_range(0, 4));
                    pm_start = pmem_address;
                end
                if (pm_cnt > 0) begin
                    pm_cnt--;
                end else begin
                    chk("pmem_addr_hold", pmem_address, pm_start);
                    chk("pmem_excl", pmem_read && pmem_write, 0);
                    pm_tx.wr   = pmem_write;
                    pm_tx.addr = pmem_address;
                    if (pmem_write) begin
                        pm_tx.data = pmem_wdata;
                        pmem_store[pmem_address[31:5]] = pmem_wdata;
                    end else begin
                        pm_tx.data = pmem_line(pmem_address[31:5]);
                        pmem_rdata = pm_tx.data;
                    end
                    txq.push_back(pm_tx);
                    pmem_resp = 1'b1;
                    pm_busy   = 1'b0;
                end
            end
        end
    end

    task automatic do_access(input bit wr, input logic [31:0] a, input logic [31:0] wd,
                             input logic [3:0] be, output logic [31:0] rd);
        int           idx, cyc, exp_tx;
        bit           got, exp_hit, exp_wb;
        logic [31:0]  victim, w;
        logic [255:0] victim_line;
        idx         = int'(a[7:5]);
        exp_hit     = cval[idx] && ctag[idx] == a[31:8];
        exp_wb      = !exp_hit && cval[idx] && cdirty[idx];
        victim      = {ctag[idx], a[7:5], 5'b0};
        victim_line = ref_line(victim[31:5]);
        exp_tx      = exp_hit ? 0 : (exp_wb ? 2 : 1);
        txq.delete();
        @(negedge clk);
        mem_read        = !wr;
        mem_write       = wr;
        mem_address     = a;
        mem_wdata       = wd;
        mem_byte_enable = be;
        cyc = 0;
        got = 1'b0;
        while (!got && cyc < 200) begin
            @(posedge clk);
            #1;
            cyc++;
            if (mem_resp) got = 1'b1;
        end
        rd        = mem_rdata;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        chk("resp_seen", got, 1);
        chk("hit_latency", cyc == 1, exp_hit);
        if (!wr) begin
            chk("rdata", rd, ref_word(a));
        end else begin
            w = ref_word(a);
            for (int b = 0; b < 4; b++) if (be[b]) w[8*b +: 8] = wd[8*b +: 8];
            ref_mem[a[31:2]] = w;
        end
        @(posedge clk);
        #1;
        chk("resp_pulse", mem_resp, 0);
        chk("pmem_tx_count", txq.size(), exp_tx);
        if (txq.size() == exp_tx && exp_tx > 0) begin
            if (exp_wb) begin
                chk("wb_is_write", txq[0].wr, 1);
                chk("wb_addr", txq[0].addr, victim);
                chk("wb_data", txq[0].data, victim_line);
            end
            chk("fill_is_read", txq[exp_tx-1].wr, 0);
            chk("fill_addr", txq[exp_tx-1].addr, {a[31:5], 5'b0});
        end
        if (!exp_hit) begin
            ctag[idx]   = a[31:8];
            cval[idx]   = 1'b1;
            cdirty[idx] = 1'b0;
        end
        if (wr) cdirty[idx] = 1'b1;
    endtask

    logic [31:0]  rd;
    logic [255:0] seed_line;
    logic [31:0]  data8 [8];
    logic [23:0]  tag_pool [4] = '{24'h10, 24'h20, 24'h30, 24'h41};
    int           n;

    initial begin
        rst             = 1'b1;
        mem_read        = 1'b0;
        mem_write       = 1'b0;
        mem_address     = '0;
        mem_wdata       = '0;
        mem_byte_enable = '0;
        for (int i = 0; i < 8; i++) begin
            cval[i] = 1'b0; cdirty[i] = 1'b0; ctag[i] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        chk("rst_mem_resp", mem_resp, 0);
        chk("rst_pmem_read", pmem_read, 0);
        chk("rst_pmem_write", pmem_write, 0);
        chk("rst_mem_rdata", mem_rdata, 0);
        chk("rst_pmem_address", pmem_address, 0);
        chk("rst_pmem_wdata", pmem_wdata, 0);
        @(negedge clk);
        rst = 1'b0;

        // Cold read fill, then a repeat hit
        seed_line = init_line(27'h0000_1000 >> 5);
        seed_line[63:32] = 32'hDEAD_BEEF;
        pmem_store[27'h0000_1000 >> 5] = seed_line;
        do_access(1'b0, 32'h0000_1004, '0, 4'h0, rd);
        chk("cold_read_word", rd, 32'hDEAD_BEEF);
        do_access(1'b0, 32'h0000_1004, '0, 4'h0, rd);
        chk("repeat_read_word", rd, 32'hDEAD_BEEF);

        // Partial write hit then read back
        do_access(1'b1, 32'h0000_1004, 32'h1234_5678, 4'b0011, rd);
        do_access(1'b0, 32'h0000_1004, '0, 4'h0, rd);
        chk("partial_write_word", rd, 32'hDEAD_5678);

        // Dirty eviction: writeback of 0x1000 precedes fill of 0x2000
        do_access(1'b0, 32'h0000_2004, '0, 4'h0, rd);
        chk("wb_line_word1", pmem_store[27'h0000_1000 >> 5][63:32], 32'hDEAD_5678);

        // Clean miss with slow memory
        fixed_delay = 10;
        do_access(1'b0, 32'h0000_3024, '0, 4'h0, rd);

        // Reset in the middle of a writeback
        fixed_delay = 20;
        do_access(1'b1, 32'h0000_2008, 32'hCAFE_F00D, 4'hF, rd);
        @(negedge clk);
        mem_read    = 1'b1;
        mem_address = 32'h0000_1004;
        n = 0;
        while (!pmem_write && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("wb_started", pmem_write, 1);
        #2;
        rst      = 1'b1;
        mem_read = 1'b0;
        #1;
        chk("rst_drops_pmem_write", pmem_write, 0);
        chk("rst_no_pmem_read", pmem_read, 0);
        chk("rst_no_mem_resp", mem_resp, 0);
        for (int i = 0; i < 8; i++) begin
            if (cdirty[i])
                for (int w = 0; w < 8; w++) ref_mem.delete({ctag[i], 3'(i), 3'(w)});
            cval[i]   = 1'b0;
            cdirty[i] = 1'b0;
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        txq.delete();
        fixed_delay = -1;
        do_access(1'b0, 32'h0000_1004, '0, 4'h0, rd);
        do_access(1'b0, 32'h0000_2008, '0, 4'h0, rd);

        // Fill every set by write, then every read must hit
        for (int i = 0; i < 8; i++) begin
            data8[i] = $urandom;
            do_access(1'b1, {24'h55, 3'(i), 3'd3, 2'b00}, data8[i], 4'hF, rd);
        end
        for (int i = 0; i < 8; i++) begin
            do_access(1'b0, {24'h55, 3'(i), 3'd3, 2'b00}, '0, 4'h0, rd);
            chk("set_readback", rd, data8[i]);
        end

        // Random traffic over a small tag pool to force hits and evictions
        for (int k = 0; k < 400; k++) begin
            do_access(1'($urandom_range(0, 1)),
                      {tag_pool[$urandom_range(0, 3)], 3'($urandom_range(0, 7)),
                       3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))},
                      $urandom, 4'($urandom_range(0, 15)), rd);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
